// File: rtl/memory_bus_if.sv
`default_nettype none
// ============================================================================
// memory_bus_if : request/response bundle between the core and memory_bus
// Revision: 1.0
// ============================================================================
interface memory_bus_if;
    logic        memory_enable;
    logic        memory_command;
    logic [31:0] read_memory_address;
    logic [31:0] write_memory_address;
    logic [31:0] write_memory_data;
    logic [31:0] write_memory_mask;
    logic        memory_ready;
    logic        memory_valid;
    logic [31:0] read_memory_data;
    logic        bus_error;
    logic        timer_interrupt;

    modport master (
        output memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask,
        input  memory_ready, memory_valid, read_memory_data, bus_error,
               timer_interrupt
    );

    modport slave (
        input  memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask,
        output memory_ready, memory_valid, read_memory_data, bus_error,
               timer_interrupt
    );
endinterface
`default_nettype wire

// File: rtl/memory_bus.sv
`default_nettype none
// ============================================================================
// memory_bus : single memory/MMIO target -- word RAM plus optional mtime timer
// Optional feature macro: MEMORY_BUS_TIMER_EN (timer region and interrupt)
// Revision: 1.0
// ============================================================================
module memory_bus #(
    parameter int          RAM_WORDS   = 4096,
    parameter int          RAM_LATENCY = 1,
    parameter logic [31:0] TIMER_BASE  = 32'h0200_0000
) (
    input  wire         clk,
    input  wire         reset,
    memory_bus_if.slave bus
);
    localparam int         c_IDX_W   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [3:0] c_LAT_M1  = (RAM_LATENCY > 0) ? 4'(RAM_LATENCY - 1) : 4'd0;
    localparam bit         c_HAS_LAT = (RAM_LATENCY > 0);
`ifdef MEMORY_BUS_TIMER_EN
    localparam bit         c_TIMER_EN = 1'b1;
`else
    localparam bit         c_TIMER_EN = 1'b0;
`endif

    // INIT keeps memory_ready low until the first edge after reset release
    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic               r_cmd;
    logic [29:0]        r_word;
    logic [31:0]        r_data;
    logic [31:0]        r_mask;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [RAM_WORDS];

    logic               w_accept;
    logic               w_commit;
    logic               w_cmd;
    logic [29:0]        w_word;
    logic [31:0]        w_data;
    logic [31:0]        w_mask;
    logic               w_ram_hit;
    logic               w_tmr_hit;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_tmr_rdata;
    logic [31:0]        w_rd_value;

    // In IDLE the live bus request is decoded; afterwards the captured copy
    assign w_accept  = (r_state == c_ST_IDLE) && bus.memory_enable;
    assign w_cmd     = (r_state == c_ST_IDLE) ? bus.memory_command : r_cmd;
    assign w_word    = (r_state != c_ST_IDLE) ? r_word :
                       bus.memory_command ? bus.write_memory_address[31:2]
                                          : bus.read_memory_address[31:2];
    assign w_data    = (r_state == c_ST_IDLE) ? bus.write_memory_data : r_data;
    assign w_mask    = (r_state == c_ST_IDLE) ? bus.write_memory_mask : r_mask;
    assign w_ram_hit = (w_word < 30'(RAM_WORDS));
    assign w_tmr_hit = c_TIMER_EN && !w_ram_hit && (w_word[29:2] == TIMER_BASE[31:4]);
    assign w_idx     = w_word[c_IDX_W-1:0];
    assign w_commit  = (w_accept && !(w_ram_hit && c_HAS_LAT)) ||
                       ((r_state == c_ST_WAIT) && (r_cnt == 4'd0));
    assign w_rd_value = w_ram_hit ? r_mem[w_idx] : (w_tmr_hit ? w_tmr_rdata : 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_INIT: w_next_state = c_ST_IDLE;
            c_ST_IDLE: if (bus.memory_enable)
                           w_next_state = (w_ram_hit && c_HAS_LAT) ? c_ST_WAIT : c_ST_RESP;
            c_ST_WAIT: if (r_cnt == 4'd0) w_next_state = c_ST_RESP;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.memory_ready     = (r_state == c_ST_IDLE);
        bus.memory_valid     = (r_state == c_ST_RESP);
        bus.bus_error        = (r_state == c_ST_RESP) && r_err;
        bus.read_memory_data = r_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_cmd   <= 1'b0;
            r_word  <= 30'd0;
            r_data  <= 32'd0;
            r_mask  <= 32'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cmd  <= bus.memory_command;
                r_word <= w_word;
                r_data <= bus.write_memory_data;
                r_mask <= bus.write_memory_mask;
                r_cnt  <= c_LAT_M1;
            end else if ((r_state == c_ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err   <= !w_ram_hit && !w_tmr_hit;
                r_rdata <= w_cmd ? 32'd0 : w_rd_value;
            end
        end
    end

    // RAM writes land on the edge entering RESP, so a reset during WAIT drops them
    always_ff @(posedge clk) begin
        if (w_commit && w_cmd && w_ram_hit)
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_data & w_mask);
    end

`ifdef MEMORY_BUS_TIMER_EN
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_mtimecmp_nxt;
    logic        w_tmr_wr;

    assign w_mtime_inc = r_mtime + 64'd1;
    assign w_tmr_wr    = w_commit && w_cmd && w_tmr_hit;

    // A written mtime half overrides the increment; the other half keeps the carry
    always_comb begin
        w_mtime_nxt    = w_mtime_inc;
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_tmr_wr) begin
            case (w_word[1:0])
                2'd0:    w_mtime_nxt[31:0]     = (r_mtime[31:0]     & ~w_mask) | (w_data & w_mask);
                2'd1:    w_mtime_nxt[63:32]    = (r_mtime[63:32]    & ~w_mask) | (w_data & w_mask);
                2'd2:    w_mtimecmp_nxt[31:0]  = (r_mtimecmp[31:0]  & ~w_mask) | (w_data & w_mask);
                default: w_mtimecmp_nxt[63:32] = (r_mtimecmp[63:32] & ~w_mask) | (w_data & w_mask);
            endcase
        end
    end

    always_comb begin
        w_tmr_rdata = 32'd0;
        case (w_word[1:0])
            2'd0:    w_tmr_rdata = r_mtime[31:0];
            2'd1:    w_tmr_rdata = r_mtime[63:32];
            2'd2:    w_tmr_rdata = r_mtimecmp[31:0];
            default: w_tmr_rdata = r_mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_irq      <= (r_mtime >= r_mtimecmp);
        end
    end

    assign bus.timer_interrupt = r_irq;
`else
    assign w_tmr_rdata         = 32'd0;
    assign bus.timer_interrupt = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_memory_bus.sv
`default_nettype none
// ============================================================================
// tb_memory_bus : directed stimulus, per-cycle comparison against a bench model
// Revision: 1.0
// ============================================================================
module tb_memory_bus;
    localparam int          c_WORDS = 4096;
    localparam int          c_LAT   = 1;
    localparam logic [31:0] c_TB    = 32'h0200_0000;
`ifdef MEMORY_BUS_TIMER_EN
    localparam bit          c_TEN   = 1'b1;
`else
    localparam bit          c_TEN   = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    memory_bus_if bus_if ();

    memory_bus #(
        .RAM_WORDS   (c_WORDS),
        .RAM_LATENCY (c_LAT),
        .TIMER_BASE  (c_TB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [int unsigned];
    logic [63:0] m_mtime = 64'd0;
    logic [63:0] m_mtcmp = '1;
    bit          m_live = 0;
    bit          m_busy = 0;
    int unsigned cyc = 0;
    int unsigned m_resp_edge = 0;
    logic        p_cmd;
    logic [31:0] p_addr, p_data, p_mask;
    int          p_kind;
    logic        exp_ready = 0, exp_valid = 0, exp_err = 0, exp_irq = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic [63:0] mt_nxt;
    logic        irq_nxt;
    logic [31:0] old_w;

    // 0 = RAM, 1 = timer, 2 = unmapped
    function automatic int kind_of(input logic [31:0] a);
        if ({2'b00, a[31:2]} < 32'(c_WORDS)) return 0;
        if (c_TEN && a[31:4] == c_TB[31:4]) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        int unsigned w;
        w = {2'b00, a[31:2]};
        return m_ram.exists(w) ? m_ram[w] : 32'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_live = 0; m_busy = 0; m_mtime = 64'd0; m_mtcmp = '1;
            exp_ready = 0; exp_valid = 0; exp_err = 0; exp_irq = 0; exp_rdata = 32'd0;
        end else begin
            cyc++;
            irq_nxt = c_TEN && (m_mtime >= m_mtcmp);
            mt_nxt  = m_mtime + 64'd1;
            exp_valid = 0;
            exp_err   = 0;
            if (m_busy && cyc == m_resp_edge + 1) m_busy = 0;
            if (exp_ready && bus_if.memory_enable) begin
                p_cmd  = bus_if.memory_command;
                p_addr = p_cmd ? bus_if.write_memory_address : bus_if.read_memory_address;
                p_data = bus_if.write_memory_data;
                p_mask = bus_if.write_memory_mask;
                p_kind = kind_of(p_addr);
                m_resp_edge = cyc + ((p_kind == 0) ? c_LAT : 0);
                m_busy = 1;
            end
            if (m_busy && cyc == m_resp_edge) begin
                exp_valid = 1;
                exp_err   = (p_kind == 2);
                if (p_cmd) begin
                    exp_rdata = 32'd0;
                    if (p_kind == 0) begin
                        old_w = ram_rd(p_addr);
                        m_ram[{2'b00, p_addr[31:2]}] = (old_w & ~p_mask) | (p_data & p_mask);
                    end else if (p_kind == 1) begin
                        case (p_addr[3:2])
                            2'd0: mt_nxt[31:0]   = (m_mtime[31:0]  & ~p_mask) | (p_data & p_mask);
                            2'd1: mt_nxt[63:32]  = (m_mtime[63:32] & ~p_mask) | (p_data & p_mask);
                            2'd2: m_mtcmp[31:0]  = (m_mtcmp[31:0]  & ~p_mask) | (p_data & p_mask);
                            default: m_mtcmp[63:32] = (m_mtcmp[63:32] & ~p_mask) | (p_data & p_mask);
                        endcase
                    end
                end else begin
                    case (p_kind)
                        0: exp_rdata = ram_rd(p_addr);
                        1: exp_rdata = (p_addr[3:2] == 2'd0) ? m_mtime[31:0]  :
                                       (p_addr[3:2] == 2'd1) ? m_mtime[63:32] :
                                       (p_addr[3:2] == 2'd2) ? m_mtcmp[31:0]  : m_mtcmp[63:32];
                        default: exp_rdata = 32'd0;
                    endcase
                end
            end
            m_mtime   = mt_nxt;
            exp_irq   = irq_nxt;
            m_live    = 1;
            exp_ready = m_live && !m_busy;
        end
    end

    always @(negedge clk) begin
        chk("ready", {31'd0, bus_if.memory_ready}, {31'd0, exp_ready});
        chk("valid", {31'd0, bus_if.memory_valid}, {31'd0, exp_valid});
        chk("bus_error", {31'd0, bus_if.bus_error}, {31'd0, exp_err});
        chk("rdata", bus_if.read_memory_data, exp_rdata);
        chk("irq", {31'd0, bus_if.timer_interrupt}, {31'd0, exp_irq});
    end

    // ---------------- stimulus ----------------
    int   last_lat;
    logic last_err;

    task automatic txn(input logic cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] mask);
        int n;
        n = 0;
        while (!exp_ready && n < 40) begin @(negedge clk); n++; end
        if (!exp_ready) begin timeout("txn_ready"); return; end
        bus_if.memory_enable        = 1'b1;
        bus_if.memory_command       = cmd;
        bus_if.read_memory_address  = cmd ? 32'hFFFF_FFF0 : addr;
        bus_if.write_memory_address = cmd ? addr : 32'hFFFF_FFF0;
        bus_if.write_memory_data    = data;
        bus_if.write_memory_mask    = mask;
        @(negedge clk);
        bus_if.memory_enable = 1'b0;
        last_lat = 0;
        last_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (bus_if.memory_valid === 1'b1) begin
                last_lat = k;
                last_err = bus_if.bus_error;
                break;
            end
            @(negedge clk);
        end
        if (last_lat == 0) timeout("txn_valid");
    endtask

    initial begin
        int nv, nr;
        bus_if.memory_enable        = 1'b0;
        bus_if.memory_command       = 1'b0;
        bus_if.read_memory_address  = 32'd0;
        bus_if.write_memory_address = 32'd0;
        bus_if.write_memory_data    = 32'd0;
        bus_if.write_memory_mask    = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus_if.memory_ready}, 32'd0);
        chk("rst_rdata", bus_if.read_memory_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, bus_if.memory_ready}, 32'd1);

        // timer compare and interrupt
        txn(1'b1, c_TB + 32'h8, 32'd100, 32'hFFFF_FFFF);
        txn(1'b1, c_TB + 32'hC, 32'd0,   32'hFFFF_FFFF);
        chk("tmr_wr_err", {31'd0, last_err}, {31'd0, !c_TEN});
        chk("irq_before", {31'd0, bus_if.timer_interrupt}, 32'd0);
        repeat (120) @(negedge clk);
        chk("irq_after", {31'd0, bus_if.timer_interrupt}, {31'd0, c_TEN});
        txn(1'b1, c_TB + 32'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'd0, bus_if.timer_interrupt}, 32'd0);
        txn(1'b0, c_TB, 32'd0, 32'd0);
        chk("tmr_rd_lat", 32'(last_lat), 32'd1);
        // mtime low write then carry into the high half
        txn(1'b1, c_TB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        txn(1'b0, c_TB + 32'h4, 32'd0, 32'd0);
        chk("mtime_carry", bus_if.read_memory_data, c_TEN ? 32'd1 : 32'd0);

        // RAM full and masked access
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        chk("ram_wr_lat", 32'(last_lat), 32'(c_LAT + 1));
        chk("wr_rdata_zero", bus_if.read_memory_data, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 32'd0);
        chk("ram_rd", bus_if.read_memory_data, 32'hDEAD_BEEF);
        chk("ram_rd_lat", 32'(last_lat), 32'(c_LAT + 1));
        txn(1'b1, 32'h20, 32'h1122_3344, 32'hFFFF_FFFF);
        txn(1'b1, 32'h20, 32'hAABB_CCDD, 32'h0000_FF00);
        txn(1'b0, 32'h20, 32'd0, 32'd0);
        chk("masked_rd", bus_if.read_memory_data, 32'h1122_CC44);

        // RAM edge and unmapped space
        txn(1'b1, 32'h3FFC, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        txn(1'b0, 32'h3FFC, 32'd0, 32'd0);
        chk("ram_top", bus_if.read_memory_data, 32'hCAFE_F00D);
        chk("ram_top_err", {31'd0, last_err}, 32'd0);
        txn(1'b0, 32'h4000, 32'd0, 32'd0);
        chk("past_ram_err", {31'd0, last_err}, 32'd1);
        txn(1'b0, 32'h8000_0000, 32'd0, 32'd0);
        chk("unmapped_rd", bus_if.read_memory_data, 32'd0);
        chk("unmapped_err", {31'd0, last_err}, 32'd1);
        chk("unmapped_lat", 32'(last_lat), 32'd1);
        txn(1'b1, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
        txn(1'b0, 32'h10, 32'd0, 32'd0);
        chk("ram_kept", bus_if.read_memory_data, 32'hDEAD_BEEF);

        // back-to-back reads with enable held
        nv = 0;
        nr = 0;
        while (!exp_ready) @(negedge clk);
        bus_if.memory_enable       = 1'b1;
        bus_if.memory_command      = 1'b0;
        bus_if.read_memory_address = 32'h20;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (bus_if.memory_valid === 1'b1) nv++;
            if (bus_if.memory_ready === 1'b1) nr++;
        end
        bus_if.memory_enable = 1'b0;
        chk("b2b_valids", 32'(nv), 32'd3);
        chk("b2b_ready_cycles", 32'(nr), 32'd3);

        // reset during the wait of a RAM write
        txn(1'b1, 32'h40, 32'h0000_0055, 32'hFFFF_FFFF);
        while (!exp_ready) @(negedge clk);
        bus_if.memory_enable        = 1'b1;
        bus_if.memory_command       = 1'b1;
        bus_if.write_memory_address = 32'h40;
        bus_if.write_memory_data    = 32'h0000_00AA;
        bus_if.write_memory_mask    = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_if.memory_enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_ready", {31'd0, bus_if.memory_ready}, 32'd0);
        chk("async_valid", {31'd0, bus_if.memory_valid}, 32'd0);
        chk("async_err", {31'd0, bus_if.bus_error}, 32'd0);
        chk("async_rdata", bus_if.read_memory_data, 32'd0);
        chk("async_irq", {31'd0, bus_if.timer_interrupt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rerelease", {31'd0, bus_if.memory_ready}, 32'd1);
        txn(1'b0, 32'h40, 32'd0, 32'd0);
        chk("aborted_write", bus_if.read_memory_data, 32'h0000_0055);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
